// File: rtl/vga_pixel_scanner.sv
// Raster timing generator and pixel output stage: scans pixelX/pixelY, then registers
// the object-mux colour together with sync/blank delayed to the same cycle.
module vga_pixel_scanner #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int OBJ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  RGBIn,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        startOfFrame,
  output logic [7:0]  oVGA_R,
  output logic [7:0]  oVGA_G,
  output logic [7:0]  oVGA_B,
  output logic        oVGA_HS,
  output logic        oVGA_VS,
  output logic        oVGA_BLANK_N
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_chk_width
    $error("vga_pixel_scanner: timing totals exceed 11-bit counters");
  end
  if (OBJ_LATENCY < 1 || OBJ_LATENCY > 3) begin : g_chk_lat
    $error("vga_pixel_scanner: OBJ_LATENCY must be 1..3");
  end

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEGIN = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_BEGIN = 11'(V_ACTIVE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [10:0] r_hCount, r_vCount;
  logic [10:0] w_hNext, w_vNext;
  logic        r_sof;
  logic        w_act0, w_hsN0, w_vsN0;
  logic [OBJ_LATENCY-1:0] r_actDly, r_hsDly, r_vsDly;
  logic        w_actD, w_hsD, w_vsD;
  logic [7:0]  r_R, r_G, r_B;
  logic        r_hs, r_vs, r_blankN;

  always_comb begin
    w_hNext = r_hCount + 11'd1;
    w_vNext = r_vCount;
    if (r_hCount == H_LAST) begin
      w_hNext = '0;
      w_vNext = (r_vCount == V_LAST) ? '0 : r_vCount + 11'd1;
    end
  end

  // startOfFrame is decoded from the next count so it is high in the same
  // clock that pixelX/pixelY read (0, V_ACTIVE).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hCount <= '0;
      r_vCount <= '0;
      r_sof    <= 1'b0;
    end else begin
      r_hCount <= w_hNext;
      r_vCount <= w_vNext;
      r_sof    <= (w_hNext == '0) && (w_vNext == V_ACT);
    end
  end

  assign w_act0 = (r_hCount < H_ACT) && (r_vCount < V_ACT);
  assign w_hsN0 = !((r_hCount >= HS_BEGIN) && (r_hCount < HS_END));
  assign w_vsN0 = !((r_vCount >= VS_BEGIN) && (r_vCount < VS_END));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_actDly <= '0;
      r_hsDly  <= '1;
      r_vsDly  <= '1;
    end else begin
      r_actDly[0] <= w_act0;
      r_hsDly[0]  <= w_hsN0;
      r_vsDly[0]  <= w_vsN0;
      for (int i = 1; i < OBJ_LATENCY; i++) begin
        r_actDly[i] <= r_actDly[i-1];
        r_hsDly[i]  <= r_hsDly[i-1];
        r_vsDly[i]  <= r_vsDly[i-1];
      end
    end
  end

  assign w_actD = r_actDly[OBJ_LATENCY-1];
  assign w_hsD  = r_hsDly[OBJ_LATENCY-1];
  assign w_vsD  = r_vsDly[OBJ_LATENCY-1];

  // RGB332 expansion replicates the MSBs so full-scale codes reach 8'hFF.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_R      <= '0;
      r_G      <= '0;
      r_B      <= '0;
      r_hs     <= 1'b1;
      r_vs     <= 1'b1;
      r_blankN <= 1'b0;
    end else begin
      r_hs     <= w_hsD;
      r_vs     <= w_vsD;
      r_blankN <= w_actD;
      if (w_actD) begin
        r_R <= {RGBIn[7:5], RGBIn[7:5], RGBIn[7:6]};
        r_G <= {RGBIn[4:2], RGBIn[4:2], RGBIn[4:3]};
        r_B <= {4{RGBIn[1:0]}};
      end else begin
        r_R <= '0;
        r_G <= '0;
        r_B <= '0;
      end
    end
  end

  assign pixelX       = r_hCount;
  assign pixelY       = r_vCount;
  assign startOfFrame = r_sof;
  assign oVGA_R       = r_R;
  assign oVGA_G       = r_G;
  assign oVGA_B       = r_B;
  assign oVGA_HS      = r_hs;
  assign oVGA_VS      = r_vs;
  assign oVGA_BLANK_N = r_blankN;
endmodule

// File: tb/tb_vga_pixel_scanner.sv
// Directed bench for vga_pixel_scanner on a shrunken raster (30x20 totals) so whole
// frames fit in a short run; a second instance uses OBJ_LATENCY = 3.
module tb_vga_pixel_scanner;
  // Small timing: H 16/4/6/4 -> 30, HS low at x 20..25; V 12/2/3/3 -> 20, VS low at y 14..16.
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  RGBIn;
  logic [10:0] pixelX, pixelY, pixelX3, pixelY3;
  logic        sof, sof3;
  logic [7:0]  R, G, B, R3, G3, B3;
  logic        hs, vs, blankN, hs3, vs3, blankN3;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  vga_pixel_scanner #(
    .H_ACTIVE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
    .V_ACTIVE(12), .V_FRONT(2), .V_SYNC(3), .V_BACK(3), .OBJ_LATENCY(1)
  ) u_dut1 (
    .clk(clk), .reset(reset), .RGBIn(RGBIn), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(sof), .oVGA_R(R), .oVGA_G(G), .oVGA_B(B),
    .oVGA_HS(hs), .oVGA_VS(vs), .oVGA_BLANK_N(blankN)
  );

  vga_pixel_scanner #(
    .H_ACTIVE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
    .V_ACTIVE(12), .V_FRONT(2), .V_SYNC(3), .V_BACK(3), .OBJ_LATENCY(3)
  ) u_dut3 (
    .clk(clk), .reset(reset), .RGBIn(RGBIn), .pixelX(pixelX3), .pixelY(pixelY3),
    .startOfFrame(sof3), .oVGA_R(R3), .oVGA_G(G3), .oVGA_B(B3),
    .oVGA_HS(hs3), .oVGA_VS(vs3), .oVGA_BLANK_N(blankN3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_xy(input int x, input int y);
    int n = 0;
    while (!(pixelX == 11'(x) && pixelY == 11'(y)) && n < 2000) begin
      step();
      n++;
    end
    chk($sformatf("reach_%0d_%0d", x, y), 32'(n < 2000), 32'd1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_x"}, 32'(pixelX), 0);
    chk({tag, "_y"}, 32'(pixelY), 0);
    chk({tag, "_sof"}, 32'(sof), 0);
    chk({tag, "_rgb"}, {8'h0, R, G, B}, 0);
    chk({tag, "_blank"}, 32'(blankN), 0);
    chk({tag, "_hs"}, 32'(hs), 1);
    chk({tag, "_vs"}, 32'(vs), 1);
    chk({tag, "_hs3"}, 32'(hs3), 1);
    chk({tag, "_blank3"}, 32'(blankN3), 0);
  endtask

  initial begin
    int cnt, nsof, nvs, sx, sy;
    reset = 1'b1;
    RGBIn = 8'h00;
    repeat (5) step();
    chk_reset_outs("rst");

    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("start_x%0d", i), 32'(pixelX), 32'(i));
      chk($sformatf("start_y%0d", i), 32'(pixelY), 0);
      step();
    end

    // Line wrap and HS width
    wait_xy(29, 10);
    step();
    chk("wrap_x", 32'(pixelX), 0);
    chk("wrap_y", 32'(pixelY), 11);
    wait_xy(20, 11);
    step();
    chk("hs_still_hi", 32'(hs), 1);
    step();
    chk("hs_low", 32'(hs), 0);
    cnt = 0;
    while (hs == 1'b0 && cnt < 100) begin
      cnt++;
      step();
    end
    chk("hs_width", 32'(cnt), 6);

    // Colour expansion
    wait_xy(5, 3);
    RGBIn = 8'h5B;
    repeat (3) step();
    chk("c5b_R", 32'(R), 32'h49);
    chk("c5b_G", 32'(G), 32'hDB);
    chk("c5b_B", 32'(B), 32'hFF);
    chk("c5b_blank", 32'(blankN), 1);
    chk("c5b_R3", 32'(R3), 32'h49);
    RGBIn = 8'hE0;
    repeat (3) step();
    chk("ce0_R", 32'(R), 32'hFF);
    chk("ce0_G", 32'(G), 32'h00);
    chk("ce0_B", 32'(B), 32'h00);
    chk("ce0_G3", 32'(G3), 32'h00);

    // Transparent white during blanking must not leak
    RGBIn = 8'hFF;
    wait_xy(20, 3);
    chk("hblank_rgb", {8'h0, R, G, B}, 0);
    chk("hblank_blank", 32'(blankN), 0);
    chk("hblank_rgb3", {8'h0, R3, G3, B3}, 0);
    wait_xy(5, 13);
    chk("vblank_rgb", {8'h0, R, G, B}, 0);
    chk("vblank_blank", 32'(blankN), 0);

    // Frame wrap and first-pixel latency
    wait_xy(29, 19);
    step();
    chk("fwrap_x", 32'(pixelX), 0);
    chk("fwrap_y", 32'(pixelY), 0);
    step();
    chk("lat1_c1", 32'(R), 0);
    step();
    chk("lat1_c2", 32'(R), 32'hFF);
    chk("lat1_blank", 32'(blankN), 1);
    chk("lat3_c2", 32'(R3), 0);
    step();
    chk("lat3_c3", 32'(R3), 0);
    step();
    chk("lat3_c4", 32'(R3), 32'hFF);
    chk("lat3_blank", 32'(blankN3), 1);

    // One full frame window: single SOF at (0,12), VS low 3 lines
    nsof = 0; nvs = 0; sx = -1; sy = -1;
    for (int i = 0; i < 600; i++) begin
      step();
      if (sof) begin
        nsof++;
        sx = int'(pixelX);
        sy = int'(pixelY);
      end
      if (!vs) nvs++;
    end
    chk("sof_count", 32'(nsof), 1);
    chk("sof_x", 32'(sx), 0);
    chk("sof_y", 32'(sy), 12);
    chk("vs_width", 32'(nvs), 90);

    // Mid-frame reset while both syncs are low
    wait_xy(22, 15);
    chk("pre_rst_hs", 32'(hs), 0);
    chk("pre_rst_vs", 32'(vs), 0);
    reset = 1'b1;
    step();
    chk_reset_outs("midrst");
    reset = 1'b0;
    cnt = 0;
    while (!sof && cnt < 1000) begin
      step();
      cnt++;
    end
    chk("sof_after_rst", 32'(cnt), 360);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
